// File: rtl/xnor_behavioral.sv
// Bitwise XNOR with optional registered copy, an all-equal flag and a saturating match counter.
// Define XNOR_BEHAVIORAL_REG_EN to register y_q/all_eq; otherwise they follow Y and &Y combinationally.
`timescale 1ns/1ps
module xnor_behavioral #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  output logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] y_q,
  output logic             all_eq,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic match;

  // A continuous assign keeps X/Z on any input bit visible as X on Y.
  assign Y     = ~(A ^ B);
  assign match = &Y;

  assign cnt_sat = (eq_cnt == CNT_MAX);

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_cnt <= '0;
    end else if (clr) begin
      eq_cnt <= '0;
    end else if (en && match && !cnt_sat) begin
      eq_cnt <= eq_cnt + 1'b1;
    end
  end

`ifdef XNOR_BEHAVIORAL_REG_EN
  // Reset value is the XNOR of two zero operands, so the flag starts asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '1;
      all_eq <= 1'b1;
    end else if (en) begin
      y_q    <= Y;
      all_eq <= match;
    end
  end
`else
  assign y_q    = Y;
  assign all_eq = match;
`endif

endmodule

// File: tb/tb_xnor_behavioral.sv
// Directed bench for xnor_behavioral: a 4-bit/8-bit-count instance and a 1-bit/2-bit-count instance.
`timescale 1ns/1ps
module tb_xnor_behavioral;

`ifdef XNOR_BEHAVIORAL_REG_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;

  logic [3:0] a4 = '0, b4 = '0, y4, yq4;
  logic       ae4, sat4, en4 = 1'b0, clr4 = 1'b0;
  logic [7:0] cnt4;

  logic       a1 = 1'b0, b1 = 1'b0, y1, yq1;
  logic       ae1, sat1, en1 = 1'b0, clr1 = 1'b0;
  logic [1:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xnor_behavioral #(.WIDTH(4), .CNT_W(8)) dut4 (
    .Y(y4), .A(a4), .B(b4), .clk(clk), .rst_n(rst_n), .en(en4), .clr(clr4),
    .y_q(yq4), .all_eq(ae4), .eq_cnt(cnt4), .cnt_sat(sat4)
  );

  xnor_behavioral #(.WIDTH(1), .CNT_W(2)) dut1 (
    .Y(y1), .A(a1), .B(b1), .clk(clk), .rst_n(rst_n), .en(en1), .clr(clr1),
    .y_q(yq1), .all_eq(ae1), .eq_cnt(cnt1), .cnt_sat(sat1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between clock edges must act at once.
  task automatic test_reset();
    #1;
    rst_n = 1'b0;
    a4 = 4'h3; b4 = 4'h5;
    #1;
    checks++; if (cnt4 !== 8'd0) begin errors++; $display("FAIL reset_cnt4 got %0h exp 0", cnt4); end
    checks++; if (sat4 !== 1'b0) begin errors++; $display("FAIL reset_sat4 got %b exp 0", sat4); end
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL reset_cnt1 got %0h exp 0", cnt1); end
    checks++; if (sat1 !== 1'b0) begin errors++; $display("FAIL reset_sat1 got %b exp 0", sat1); end
    checks++; if (y4 !== 4'h9) begin errors++; $display("FAIL reset_y4 got %h exp 9", y4); end
    checks++; if (yq4 !== (REG_EN ? 4'hF : 4'h9)) begin
      errors++; $display("FAIL reset_yq4 got %h exp %h", yq4, (REG_EN ? 4'hF : 4'h9)); end
    checks++; if (ae4 !== REG_EN) begin errors++; $display("FAIL reset_ae4 got %b exp %b", ae4, REG_EN); end
    a4 = 4'hC; b4 = 4'hC;
    #0.5;
    checks++; if (y4 !== 4'hF) begin errors++; $display("FAIL reset_y4_live got %h exp F", y4); end
  endtask

  // WIDTH=1 truth table at 1 ns spacing, still inside reset.
  task automatic test_comb();
    logic [3:0] tbl;
    logic [1:0] ab;
    tbl = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1]; b1 = ab[0];
      #0.1;
      checks++; if (y1 !== tbl[i]) begin errors++; $display("FAIL comb_y1[%0d] got %b exp %b", i, y1, tbl[i]); end
      checks++; if (yq1 !== (REG_EN ? 1'b1 : tbl[i])) begin
        errors++; $display("FAIL comb_yq1[%0d] got %b exp %b", i, yq1, (REG_EN ? 1'b1 : tbl[i])); end
      #0.9;
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_match();
    @(negedge clk);
    a4 = 4'hA; b4 = 4'hA; en4 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (cnt4 !== 8'(i)) begin errors++; $display("FAIL match_cnt[%0d] got %0d exp %0d", i, cnt4, i); end
      checks++; if (yq4 !== 4'hF) begin errors++; $display("FAIL match_yq[%0d] got %h exp F", i, yq4); end
      checks++; if (ae4 !== 1'b1) begin errors++; $display("FAIL match_ae[%0d] got %b exp 1", i, ae4); end
    end
    @(negedge clk);
    b4 = 4'h5;
    step();
    checks++; if (y4 !== 4'h0) begin errors++; $display("FAIL miss_y got %h exp 0", y4); end
    checks++; if (yq4 !== 4'h0) begin errors++; $display("FAIL miss_yq got %h exp 0", yq4); end
    checks++; if (ae4 !== 1'b0) begin errors++; $display("FAIL miss_ae got %b exp 0", ae4); end
    checks++; if (cnt4 !== 8'd3) begin errors++; $display("FAIL miss_cnt got %0d exp 3", cnt4); end
  endtask

  task automatic test_hold();
    logic [3:0] va [4] = '{4'h3, 4'h1, 4'hF, 4'h6};
    logic [3:0] vb [4] = '{4'h3, 4'h2, 4'h0, 4'h6};
    logic [3:0] vy [4] = '{4'hF, 4'hC, 4'h0, 4'hF};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en4 = 1'b0; a4 = va[i]; b4 = vb[i];
      step();
      checks++; if (y4 !== vy[i]) begin errors++; $display("FAIL hold_y[%0d] got %h exp %h", i, y4, vy[i]); end
      checks++; if (yq4 !== (REG_EN ? 4'h0 : vy[i])) begin
        errors++; $display("FAIL hold_yq[%0d] got %h exp %h", i, yq4, (REG_EN ? 4'h0 : vy[i])); end
      checks++; if (ae4 !== (REG_EN ? 1'b0 : (&vy[i]))) begin
        errors++; $display("FAIL hold_ae[%0d] got %b exp %b", i, ae4, (REG_EN ? 1'b0 : (&vy[i]))); end
      checks++; if (cnt4 !== 8'd3) begin errors++; $display("FAIL hold_cnt[%0d] got %0d exp 3", i, cnt4); end
    end
  endtask

  task automatic test_sat();
    logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic       es [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; en1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (cnt1 !== ec[i]) begin errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, cnt1, ec[i]); end
      checks++; if (sat1 !== es[i]) begin errors++; $display("FAIL sat_flag[%0d] got %b exp %b", i, sat1, es[i]); end
    end
    checks++; if (yq1 !== 1'b1) begin errors++; $display("FAIL sat_yq got %b exp 1", yq1); end
    checks++; if (ae1 !== 1'b1) begin errors++; $display("FAIL sat_ae got %b exp 1", ae1); end
  endtask

  task automatic test_clr();
    @(negedge clk);
    clr1 = 1'b1;
    step();
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL clr_from_sat got %0d exp 0", cnt1); end
    checks++; if (sat1 !== 1'b0) begin errors++; $display("FAIL clr_sat got %b exp 0", sat1); end
    @(negedge clk);
    clr1 = 1'b0;
    step();
    step();
    checks++; if (cnt1 !== 2'd2) begin errors++; $display("FAIL clr_recount got %0d exp 2", cnt1); end
    @(negedge clk);
    clr1 = 1'b1;
    step();
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL clr_priority got %0d exp 0", cnt1); end
    checks++; if (yq1 !== 1'b1) begin errors++; $display("FAIL clr_yq got %b exp 1", yq1); end
    checks++; if (ae1 !== 1'b1) begin errors++; $display("FAIL clr_ae got %b exp 1", ae1); end
    @(negedge clk);
    clr1 = 1'b0; en1 = 1'b0;
  endtask

  // Reset mid-count discards the count; the first update lands on the first edge after release.
  task automatic test_reset_mid();
    @(negedge clk);
    a4 = 4'h3; b4 = 4'h5; en4 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (cnt4 !== 8'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", cnt4); end
    checks++; if (yq4 !== (REG_EN ? 4'hF : 4'h9)) begin
      errors++; $display("FAIL mid_yq got %h exp %h", yq4, (REG_EN ? 4'hF : 4'h9)); end
    checks++; if (ae4 !== REG_EN) begin errors++; $display("FAIL mid_ae got %b exp %b", ae4, REG_EN); end
    @(negedge clk);
    rst_n = 1'b1; a4 = 4'h7; b4 = 4'h7;
    step();
    checks++; if (cnt4 !== 8'd1) begin errors++; $display("FAIL post_rst_cnt got %0d exp 1", cnt4); end
    checks++; if (yq4 !== 4'hF) begin errors++; $display("FAIL post_rst_yq got %h exp F", yq4); end
    checks++; if (ae4 !== 1'b1) begin errors++; $display("FAIL post_rst_ae got %b exp 1", ae4); end
  endtask

  initial begin
    test_reset();
    test_comb();
    test_release();
    test_match();
    test_hold();
    test_sat();
    test_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
